// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the MIPS execute stage.
// Bus layouts, ALU op bit positions, divider states and func codes.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 141;
  localparam int STALL_WD     = 6;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] FUNC_DIV  = 6'b011010;
  localparam logic [5:0] FUNC_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] data1;
    logic [31:0] data2;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_result;
  } ex_mem_t;

endpackage

// File: rtl/ex_div.sv
// Iterative 32-step restoring divider for div/divu.
// Works on magnitudes; signs are re-applied on the registered result.
module ex_div
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] dvd_mag;
  logic [31:0] dsr_mag;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  assign dvd_mag = (signed_op && dividend[31]) ? -dividend : dividend;
  assign dsr_mag = (signed_op && divisor[31])  ? -divisor  : divisor;
  assign rem_sh  = {rem_q, quo_q[31]};
  assign diff    = rem_sh - {1'b0, dsr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            // Zero divisor skips the iteration entirely
            if (divisor == '0) begin
              state <= DIV_DONE;
              quo_q <= '1;
              rem_q <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              state <= DIV_RUN;
              cnt   <= '0;
              rem_q <= '0;
              quo_q <= dvd_mag;
              dsr_q <= dsr_mag;
              neg_q <= signed_op && (dividend[31] ^ divisor[31]);
              neg_r <= signed_op && dividend[31];
            end
          end
        end
        DIV_RUN: begin
          if (!diff[32]) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= rem_sh[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign busy      = ((state == DIV_IDLE) && start) || (state == DIV_RUN);
  assign done      = (state == DIV_DONE);
  assign quotient  = neg_q ? -quo_q : quo_q;
  assign remainder = neg_r ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, 12-op ALU, SRAM request, EX/MEM bus.
// Define EX_DIV_EN to build the iterative div/divu unit and its stall request.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_ex_t  id_to_ex_bus_r;
  ex_mem_t mem_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      id_to_ex_bus_r <= '0;
    else if (stall[2] && !stall[3])
      id_to_ex_bus_r <= '0;
    else if (!stall[2])
      id_to_ex_bus_r <= id_to_ex_bus;
  end

  logic [31:0] inst;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_res;
  logic [4:0]  sa;

  assign inst = id_to_ex_bus_r.inst;
  assign sa   = src1[4:0];

  always_comb begin
    src1 = '0;
    unique case (1'b1)
      id_to_ex_bus_r.sel_src1[0]: src1 = id_to_ex_bus_r.data1;
      id_to_ex_bus_r.sel_src1[1]: src1 = id_to_ex_bus_r.pc;
      id_to_ex_bus_r.sel_src1[2]: src1 = {27'b0, inst[10:6]};
      default:                    src1 = '0;
    endcase
  end

  always_comb begin
    src2 = '0;
    unique case (1'b1)
      id_to_ex_bus_r.sel_src2[0]: src2 = id_to_ex_bus_r.data2;
      id_to_ex_bus_r.sel_src2[1]: src2 = {{16{inst[15]}}, inst[15:0]};
      id_to_ex_bus_r.sel_src2[2]: src2 = 32'd8;
      id_to_ex_bus_r.sel_src2[3]: src2 = {16'b0, inst[15:0]};
      default:                    src2 = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      id_to_ex_bus_r.alu_op[ALU_ADD]:  alu_res = src1 + src2;
      id_to_ex_bus_r.alu_op[ALU_SUB]:  alu_res = src1 - src2;
      id_to_ex_bus_r.alu_op[ALU_SLT]:  alu_res = {31'b0, $signed(src1) < $signed(src2)};
      id_to_ex_bus_r.alu_op[ALU_SLTU]: alu_res = {31'b0, src1 < src2};
      id_to_ex_bus_r.alu_op[ALU_AND]:  alu_res = src1 & src2;
      id_to_ex_bus_r.alu_op[ALU_NOR]:  alu_res = ~(src1 | src2);
      id_to_ex_bus_r.alu_op[ALU_OR]:   alu_res = src1 | src2;
      id_to_ex_bus_r.alu_op[ALU_XOR]:  alu_res = src1 ^ src2;
      id_to_ex_bus_r.alu_op[ALU_SLL]:  alu_res = src2 << sa;
      id_to_ex_bus_r.alu_op[ALU_SRL]:  alu_res = src2 >> sa;
      id_to_ex_bus_r.alu_op[ALU_SRA]:  alu_res = $signed(src2) >>> sa;
      id_to_ex_bus_r.alu_op[ALU_LUI]:  alu_res = {src2[15:0], 16'b0};
      default:                         alu_res = '0;
    endcase
  end

  logic is_div;
  logic hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  assign is_div = (inst[31:26] == 6'b0) &&
                  ((inst[5:0] == FUNC_DIV) || (inst[5:0] == FUNC_DIVU));

`ifdef EX_DIV_EN
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  ex_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (inst[5:0] == FUNC_DIV),
    .dividend  (id_to_ex_bus_r.data1),
    .divisor   (id_to_ex_bus_r.data2),
    .ack       (!stall[3]),
    .busy      (stallreq_for_ex),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign hilo_we = div_done;
  assign hi      = div_done ? div_r : '0;
  assign lo      = div_done ? div_q : '0;
`else
  logic unused_div;
  assign unused_div      = is_div;
  assign stallreq_for_ex = 1'b0;
  assign hilo_we         = 1'b0;
  assign hi              = '0;
  assign lo              = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

  always_comb begin
    mem_o            = '0;
    mem_o.pc         = id_to_ex_bus_r.pc;
    mem_o.ram_en     = id_to_ex_bus_r.ram_en;
    mem_o.ram_wen    = id_to_ex_bus_r.ram_wen;
    mem_o.sel_rf_res = id_to_ex_bus_r.sel_rf_res;
    mem_o.hilo_we    = hilo_we;
    mem_o.hi         = hi;
    mem_o.lo         = lo;
    mem_o.rf_we      = id_to_ex_bus_r.rf_we;
    mem_o.rf_waddr   = id_to_ex_bus_r.rf_waddr;
    mem_o.rf_result  = alu_res;
  end

  assign ex_to_mem_bus   = mem_o;
  assign data_sram_en    = id_to_ex_bus_r.ram_en;
  assign data_sram_wen   = id_to_ex_bus_r.ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = id_to_ex_bus_r.data2;

endmodule
